// File: rtl/unit_manager.sv
// rtl/unit_manager.sv - 16-slot unit table: spawn placement, lane movement, retirement scoring
module unit_manager #(
  parameter int unsigned MOVE_DIV = 1_000_000,
  parameter logic [8:0]  LANE_END = 9'd400,
  parameter logic [7:0]  COOLDOWN = 8'd20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         spawn_req,
  input  logic [1:0]   spawn_type,
  output logic         spawn_ack,
  output logic         spawn_nack,
  output logic [143:0] unit_loc,
  output logic [31:0]  unit_type,
  output logic [4:0]   live_count,
  output logic [7:0]   cat_score,
  output logic [7:0]   enemy_score,
  output logic         move_tick
);

  localparam int unsigned     DIV_W   = $clog2(MOVE_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(MOVE_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [7:0]       cool_q;
  logic [7:0]       cool_d;
  logic [8:0]       loc_q  [16];
  logic [1:0]       type_q [16];
  logic [8:0]       loc_d  [16];
  logic [1:0]       type_d [16];

  logic       free_found;
  logic [3:0] free_idx;
  logic       accept;
  logic       reject;
  logic [4:0] cat_ret;
  logic [4:0] enemy_ret;
  logic [8:0] cat_sum;
  logic [8:0] enemy_sum;

  assign move_tick = !rst && run && (div_q == DIV_MAX);

  // Lowest-index empty slot, searched on the table as it stands before this cycle's move.
  always_comb begin
    free_found = 1'b0;
    free_idx   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (type_q[i] == 2'b00) begin
        free_found = 1'b1;
        free_idx   = 4'(i);
      end
    end
  end

  assign accept = spawn_req && run && (spawn_type != 2'b00) && (cool_q == 8'd0) && free_found;
  assign reject = spawn_req && run && !accept;

  always_comb begin
    cat_ret   = 5'd0;
    enemy_ret = 5'd0;
    for (int i = 0; i < 16; i++) begin
      loc_d[i]  = loc_q[i];
      type_d[i] = type_q[i];
      if (move_tick) begin
        case (type_q[i])
          2'b01, 2'b10: begin
            if (loc_q[i] == 9'd0) begin
              type_d[i] = 2'b00;
              cat_ret   = cat_ret + 5'd1;
            end else begin
              loc_d[i] = loc_q[i] - 9'd1;
            end
          end
          2'b11: begin
            if (loc_q[i] == LANE_END) begin
              type_d[i] = 2'b00;
              loc_d[i]  = 9'd0;
              enemy_ret = enemy_ret + 5'd1;
            end else begin
              loc_d[i] = loc_q[i] + 9'd1;
            end
          end
          default: ;
        endcase
      end
      // The chosen slot is empty, so a move can never touch it in the same cycle.
      if (accept && (free_idx == 4'(i))) begin
        type_d[i] = spawn_type;
        loc_d[i]  = (spawn_type == 2'b11) ? 9'd0 : LANE_END;
      end
    end
  end

  always_comb begin
    cool_d = cool_q;
    if (accept) begin
      cool_d = COOLDOWN;
    end else if (move_tick && (cool_q != 8'd0)) begin
      cool_d = cool_q - 8'd1;
    end
  end

  assign cat_sum   = {1'b0, cat_score}   + {4'b0, cat_ret};
  assign enemy_sum = {1'b0, enemy_score} + {4'b0, enemy_ret};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        loc_q[i]  <= 9'd0;
        type_q[i] <= 2'b00;
      end
      div_q       <= '0;
      cool_q      <= 8'd0;
      cat_score   <= 8'd0;
      enemy_score <= 8'd0;
      spawn_ack   <= 1'b0;
      spawn_nack  <= 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        loc_q[i]  <= loc_d[i];
        type_q[i] <= type_d[i];
      end
      if (run) begin
        div_q <= move_tick ? '0 : div_q + 1'b1;
      end
      cool_q      <= cool_d;
      cat_score   <= cat_sum[8]   ? 8'hFF : cat_sum[7:0];
      enemy_score <= enemy_sum[8] ? 8'hFF : enemy_sum[7:0];
      spawn_ack   <= accept;
      spawn_nack  <= reject;
    end
  end

  always_comb begin
    live_count = 5'd0;
    for (int i = 0; i < 16; i++) begin
      unit_loc[9*i +: 9]  = loc_q[i];
      unit_type[2*i +: 2] = type_q[i];
      if (type_q[i] != 2'b00) begin
        live_count = live_count + 5'd1;
      end
    end
  end

endmodule
